// File: rtl/clkgen_ce_supervisor.sv
// PLL lock supervisor: releases a synchronous system reset after lock has been stable,
// then drives NUM_CH clock-enable dividers that can be reprogrammed at runtime without glitches.
// Optional lock-loss event counter: define CLKGEN_CE_LOCK_LOST_CNT_EN.
module clkgen_ce_supervisor #(
    parameter int NUM_CH             = 4,
    parameter int DIV_W              = 8,
    parameter int DIV_DEFAULT        = 2,
    parameter int LOCK_STABLE_CYCLES = 1024,
    parameter int CH_W               = 2
) (
    input  logic              clkin,
    input  logic              rst_n,
    input  logic              pll_lock,
    input  logic              div_wr,
    input  logic [CH_W-1:0]   div_ch,
    input  logic [DIV_W-1:0]  div_val,
    output logic              locked,
    output logic              sys_rst_n,
    output logic [NUM_CH-1:0] ce,
    output logic [7:0]        lock_lost_cnt
);

    localparam int SC_W = (LOCK_STABLE_CYCLES > 1) ? $clog2(LOCK_STABLE_CYCLES) : 1;
    localparam logic [SC_W-1:0]  STABLE_LAST = SC_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [DIV_W-1:0] DIV_RST     = DIV_W'(DIV_DEFAULT);

    // state     | meaning
    // WAIT_LOCK | synchronised lock low, stable counter cleared
    // STABLE    | lock seen, counting consecutive locked cycles
    // RUN       | lock stable, system reset released, dividers running
    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        STABLE    = 2'd1,
        RUN       = 2'd2
    } state_t;

    logic            lock_meta_q;
    logic            lock_s_q;
    state_t          state_q;
    logic [SC_W-1:0] stable_cnt_q;
    logic            run_q;
    logic            run_d;

    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            lock_meta_q <= 1'b0;
            lock_s_q    <= 1'b0;
        end else begin
            lock_meta_q <= pll_lock;
            lock_s_q    <= lock_meta_q;
        end
    end

    // The dividers need to know one edge ahead whether the system reset will be released.
    assign run_d = lock_s_q &&
                   ((state_q == RUN) || ((state_q == STABLE) && (stable_cnt_q == STABLE_LAST)));

    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= WAIT_LOCK;
            stable_cnt_q <= '0;
            run_q        <= 1'b0;
        end else begin
            run_q <= run_d;
            case (state_q)
                WAIT_LOCK: begin
                    stable_cnt_q <= '0;
                    if (lock_s_q) state_q <= STABLE;
                end
                STABLE: begin
                    if (!lock_s_q) begin
                        state_q      <= WAIT_LOCK;
                        stable_cnt_q <= '0;
                    end else if (stable_cnt_q == STABLE_LAST) begin
                        state_q      <= RUN;
                        stable_cnt_q <= '0;
                    end else begin
                        stable_cnt_q <= stable_cnt_q + SC_W'(1);
                    end
                end
                RUN: begin
                    if (!lock_s_q) state_q <= WAIT_LOCK;
                end
                default: begin
                    state_q      <= WAIT_LOCK;
                    stable_cnt_q <= '0;
                end
            endcase
        end
    end

    assign locked    = run_q;
    assign sys_rst_n = run_q;

`ifdef CLKGEN_CE_LOCK_LOST_CNT_EN
    logic [7:0] lost_cnt_q;

    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            lost_cnt_q <= 8'd0;
        end else if (run_q && !lock_s_q && (lost_cnt_q != 8'hFF)) begin
            lost_cnt_q <= lost_cnt_q + 8'd1;
        end
    end

    assign lock_lost_cnt = lost_cnt_q;
`else
    assign lock_lost_cnt = 8'd0;
`endif

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [DIV_W-1:0] div_q;
        logic [DIV_W-1:0] pend_q;
        logic             pend_v_q;
        logic [DIV_W-1:0] cnt_q;
        logic             ce_q;

        logic             wr_hit;
        logic             le1;
        logic             tc;
        logic             pend_v_nx;
        logic [DIV_W-1:0] pend_nx;
        logic             apply;

        always_comb begin
            wr_hit    = div_wr && (div_ch == CH_W'(i));
            le1       = (div_q <= DIV_W'(1));
            tc        = le1 || (cnt_q == (div_q - DIV_W'(1)));
            pend_v_nx = pend_v_q || wr_hit;
            pend_nx   = wr_hit ? div_val : pend_q;
            // Pending divisors only land on a period boundary, or at once while held in reset.
            apply     = pend_v_nx && (!run_q || tc);
        end

        always_ff @(posedge clkin or negedge rst_n) begin
            if (!rst_n) begin
                div_q    <= DIV_RST;
                pend_q   <= DIV_RST;
                pend_v_q <= 1'b0;
                cnt_q    <= '0;
                ce_q     <= 1'b0;
            end else begin
                ce_q   <= run_d && (le1 || (run_q && tc));
                cnt_q  <= (!run_q || !run_d || tc) ? '0 : (cnt_q + DIV_W'(1));
                pend_q <= pend_nx;
                if (apply) begin
                    div_q    <= pend_nx;
                    pend_v_q <= 1'b0;
                end else begin
                    pend_v_q <= pend_v_nx;
                end
            end
        end

        assign ce[i] = ce_q;
    end

endmodule

// File: tb/tb_clkgen_ce_supervisor.sv
// Self-checking bench for clkgen_ce_supervisor: streak/timestamp reference model plus
// directed lock, divisor-write and reset scenarios with literal expectations.
module tb_clkgen_ce_supervisor;

    localparam int NUM_CH = 4;
    localparam int DIV_W  = 8;
    localparam int L      = 4;
    localparam int CH_W   = 3;

    logic              clkin = 1'b0;
    logic              rst_n;
    logic              pll_lock;
    logic              div_wr;
    logic [CH_W-1:0]   div_ch;
    logic [DIV_W-1:0]  div_val;
    logic              locked;
    logic              sys_rst_n;
    logic [NUM_CH-1:0] ce;
    logic [7:0]        lock_lost_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clkin = ~clkin;

    clkgen_ce_supervisor #(
        .NUM_CH(NUM_CH), .DIV_W(DIV_W), .DIV_DEFAULT(2),
        .LOCK_STABLE_CYCLES(L), .CH_W(CH_W)
    ) dut (
        .clkin(clkin), .rst_n(rst_n), .pll_lock(pll_lock),
        .div_wr(div_wr), .div_ch(div_ch), .div_val(div_val),
        .locked(locked), .sys_rst_n(sys_rst_n), .ce(ce),
        .lock_lost_cnt(lock_lost_cnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: RUN holds once lock has been seen (two edges late) for L+1 edges in a row;
    // each channel fires on timestamps spaced by its divisor.
    int                n_edge = 0;
    bit                l1, l2, m_ls, m_prev, m_run;
    int                streak;
    int                m_lost;
    int                m_div [NUM_CH];
    int                m_pend[NUM_CH];
    int                m_next[NUM_CH];
    bit                m_pv  [NUM_CH];
    logic [NUM_CH-1:0] m_ce;

    always @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            l1 = 0; l2 = 0; streak = 0; m_run = 0; m_lost = 0; m_ce = '0;
            for (int i = 0; i < NUM_CH; i++) begin
                m_div[i] = 2; m_pend[i] = 0; m_next[i] = 0; m_pv[i] = 0;
            end
        end else begin
            n_edge++;
            m_ls = l2; l2 = l1; l1 = pll_lock;
            streak = m_ls ? ((streak < L + 1) ? streak + 1 : streak) : 0;
            m_prev = m_run;
            m_run  = (streak >= L + 1);
`ifdef CLKGEN_CE_LOCK_LOST_CNT_EN
            if (m_prev && !m_run && m_lost < 255) m_lost++;
`endif
            if (div_wr && div_ch < NUM_CH) begin
                m_pend[div_ch] = div_val;
                m_pv[div_ch]   = 1;
            end
            for (int i = 0; i < NUM_CH; i++) begin
                m_ce[i] = 1'b0;
                if (!m_prev) begin
                    if (m_pv[i]) begin m_div[i] = m_pend[i]; m_pv[i] = 0; end
                    if (m_run) begin
                        m_ce[i]   = (m_div[i] <= 1);
                        m_next[i] = n_edge + m_div[i];
                    end
                end else if (m_div[i] <= 1 || n_edge == m_next[i]) begin
                    m_ce[i] = m_run;
                    if (m_pv[i]) begin m_div[i] = m_pend[i]; m_pv[i] = 0; end
                    m_next[i] = n_edge + m_div[i];
                end
            end
        end
    end

    always @(posedge clkin) begin
        #1;
        chk("model_locked", locked, m_run);
        chk("model_sys_rst_n", sys_rst_n, m_run);
        chk("model_ce", ce, m_ce);
        chk("model_lock_lost_cnt", lock_lost_cnt, m_lost);
    end

    task automatic wait_ce(input int ch);
        bit found = 0;
        for (int t = 0; t < 20 && !found; t++) begin
            @(posedge clkin); #1;
            if (ce[ch]) found = 1;
        end
        chk("wait_ce_timeout", found, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1);
    end

    initial begin
        logic [7:0] exp_lost;
`ifdef CLKGEN_CE_LOCK_LOST_CNT_EN
        exp_lost = 8'd1;
`else
        exp_lost = 8'd0;
`endif
        rst_n = 0; pll_lock = 0; div_wr = 0; div_ch = '0; div_val = '0;
        repeat (3) @(negedge clkin);
        chk("rst_locked", locked, 0);
        chk("rst_sys_rst_n", sys_rst_n, 0);
        chk("rst_ce", ce, 0);
        chk("rst_lost", lock_lost_cnt, 0);
        rst_n = 1;

        // Lock held from before edge 1: release at edge 7, first D=2 strobes at edge 9.
        pll_lock = 1;
        for (int k = 1; k <= 9; k++) begin
            @(posedge clkin); #1;
            chk("t1_sys_rst_n", sys_rst_n, k >= 7);
            chk("t1_locked", locked, k >= 7);
            chk("t1_ce", ce, (k == 9) ? 4'hF : 4'h0);
        end

        // Retarget ch0 to 5 one cycle after a strobe: one more 2-period, then 5-periods.
        wait_ce(0);
        @(negedge clkin); div_wr = 1; div_ch = 0; div_val = 8'd5;
        @(posedge clkin); #1;
        @(negedge clkin); div_wr = 0;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clkin); #1;
            chk("t4_ce0", ce[0], (k == 1) || (k == 6) || (k == 11));
        end

        // D=0 and D=1 give constant enables; out-of-range channel writes are dropped.
        @(negedge clkin); div_wr = 1; div_ch = 2; div_val = 8'd0;
        @(negedge clkin); div_ch = 3; div_val = 8'd1;
        @(negedge clkin); div_ch = 4; div_val = 8'd9;
        @(negedge clkin); div_ch = 7; div_val = 8'd3;
        @(negedge clkin); div_wr = 0;
        repeat (4) @(negedge clkin);
        for (int k = 1; k <= 8; k++) begin
            @(posedge clkin); #1;
            chk("t5_ce23", ce[3:2], 2'b11);
        end

        // Lock dropped for 5 cycles: reset reasserts at the 3rd edge, full wait repeats.
        for (int k = 1; k <= 13; k++) begin
            @(negedge clkin); pll_lock = (k > 5);
            @(posedge clkin); #1;
            chk("t3_sys_rst_n", sys_rst_n, (k < 3) || (k >= 12));
            if (k >= 3 && k < 12) chk("t3_ce", ce, 0);
        end
        chk("t3_lost", lock_lost_cnt, exp_lost);
        repeat (12) @(negedge clkin);

        // Async reset with a write pending on ch1.
        wait_ce(1);
        @(negedge clkin); div_wr = 1; div_ch = 1; div_val = 8'd7;
        @(posedge clkin); #1;
        @(negedge clkin); div_wr = 0;
        #1 rst_n = 0; pll_lock = 0;
        #1;
        chk("t6_locked", locked, 0);
        chk("t6_sys_rst_n", sys_rst_n, 0);
        chk("t6_ce", ce, 0);
        chk("t6_lost", lock_lost_cnt, 0);
        repeat (2) @(negedge clkin);
        rst_n = 1;

        // Short lock pulse never reaches RUN; second rise releases 7 edges later at D=2.
        for (int k = 1; k <= 16; k++) begin
            @(negedge clkin); pll_lock = (k <= 4) || (k >= 8);
            @(posedge clkin); #1;
            chk("t2_sys_rst_n", sys_rst_n, k >= 14);
            chk("t2_ce", ce, (k == 16) ? 4'hF : 4'h0);
        end
        chk("t2_lost", lock_lost_cnt, 0);
        repeat (8) @(negedge clkin);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
